bcd_entry_to_binary: RTL and testbench

- Operator input side of the square-root demo: the opposite direction to the BCD/7-seg display path.
- Three push buttons let the operator dial in a 3-digit decimal number (000–299), one digit at a time.
- On enter, the block converts the BCD digits to binary sequentially, using reverse double-dabble.
- It presents an 8-bit operand plus a one-cycle valid strobe for the square-root finder, and drives the current digits back out for the display.

---
 rtl/bcd_entry_to_binary_pkg.sv | 32 +++
 rtl/bcd_entry_to_binary_debounce.sv | 52 +++++
 rtl/bcd_entry_to_binary.sv | 189 ++++++++++++++++++
 tb/tb_bcd_entry_to_binary.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_entry_to_binary_pkg.sv
// Shared types and constants for the BCD operand entry block: FSM state
// encoding, digit-select codes, conversion step count and the saturation value.
package bcd_entry_to_binary_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SEL_UNITS    = 2'd0;
  localparam logic [1:0] SEL_TENS     = 2'd1;
  localparam logic [1:0] SEL_HUNDREDS = 2'd2;

  // One shift per bit of the 9-bit result (0..299 fits in 9 bits).
  localparam logic [3:0] CONV_STEPS = 4'd9;
  localparam logic [7:0] SAT_VALUE  = 8'hFF;

  // Reverse double-dabble correction: after halving, a BCD nibble >= 8 carried
  // a 10 in from the digit above; subtracting 3 turns that 8+x into 5+x.
  function automatic logic [3:0] dabble_fix(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd8) begin
      res = nib - 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_entry_to_binary_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted 0->1 transition.
module button_debounce #(
  parameter int DEB_CYCLES = 250000,
  parameter int DEB_W      = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_r;
  logic             level_r;
  logic [DEB_W-1:0] cnt_r;
  logic             pulse_r;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn};
    end
  end

  // Accept a new level only after it has been stable long enough; pulse on rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= 1'b0;
      cnt_r   <= '0;
      pulse_r <= 1'b0;
    end else if (sync_r[1] != level_r) begin
      if (cnt_r == CNT_LAST) begin
        level_r <= sync_r[1];
        cnt_r   <= '0;
        pulse_r <= sync_r[1];
      end else begin
        cnt_r   <= cnt_r + {{(DEB_W-1){1'b0}}, 1'b1};
        pulse_r <= 1'b0;
      end
    end else begin
      cnt_r   <= '0;
      pulse_r <= 1'b0;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/bcd_entry_to_binary.sv
// Operator entry of a 3-digit decimal operand (000-299) via three buttons,
// converted to an 8-bit saturated binary value by sequential reverse
// double-dabble. Work register layout: [18:17]=hundreds, [16:13]=tens,
// [12:9]=units, [8:0]=binary accumulator.
module bcd_entry_to_binary
  import bcd_entry_to_binary_pkg::*;
#(
  parameter int DEB_CYCLES = 250000,
  parameter int DEB_W      = 18
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_enter,
  output logic [1:0] dig_h,
  output logic [3:0] dig_t,
  output logic [3:0] dig_u,
  output logic [1:0] sel,
  output logic       busy,
  output logic [7:0] value,
  output logic       valid,
  output logic       ovf
);

  logic p_inc_s, p_next_s, p_enter_s;

  state_e      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic [18:0] work_r, work_nxt_s, shift_s, fixed_s;
  logic [1:0]  dig_h_r, dig_h_nxt_s, sel_r, sel_nxt_s;
  logic [3:0]  dig_t_r, dig_t_nxt_s, dig_u_r, dig_u_nxt_s;
  logic        busy_r, busy_nxt_s, valid_r, valid_nxt_s, ovf_r, ovf_nxt_s;
  logic [7:0]  value_r, value_nxt_s;

  button_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_inc (
    .clk(clk), .rst_n(clr), .btn(btn_inc), .pulse(p_inc_s));
  button_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_next (
    .clk(clk), .rst_n(clr), .btn(btn_next), .pulse(p_next_s));
  button_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_enter (
    .clk(clk), .rst_n(clr), .btn(btn_enter), .pulse(p_enter_s));

  // One conversion step: halve the whole word, then correct tens and units.
  always_comb begin
    shift_s = work_r >> 5'd1;
    fixed_s = {shift_s[18:17], dabble_fix(shift_s[16:13]),
               dabble_fix(shift_s[12:9]), shift_s[8:0]};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (p_enter_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD:  state_nxt_s = ST_SHIFT;
      ST_SHIFT: begin
        if (cnt_r == (CONV_STEPS - 4'd1)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of digits, selection, work register and the registered outputs.
  always_comb begin
    dig_h_nxt_s = dig_h_r;
    dig_t_nxt_s = dig_t_r;
    dig_u_nxt_s = dig_u_r;
    sel_nxt_s   = sel_r;
    work_nxt_s  = work_r;
    cnt_nxt_s   = cnt_r;
    busy_nxt_s  = busy_r;
    value_nxt_s = value_r;
    ovf_nxt_s   = ovf_r;
    valid_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (p_enter_s) begin
          // Enter wins: digits are captured as they stand.
          busy_nxt_s = 1'b1;
        end else begin
          if (p_inc_s) begin
            case (sel_r)
              SEL_UNITS:    dig_u_nxt_s = (dig_u_r == 4'd9) ? 4'd0 : dig_u_r + 4'd1;
              SEL_TENS:     dig_t_nxt_s = (dig_t_r == 4'd9) ? 4'd0 : dig_t_r + 4'd1;
              SEL_HUNDREDS: dig_h_nxt_s = (dig_h_r == 2'd2) ? 2'd0 : dig_h_r + 2'd1;
              default:      dig_u_nxt_s = dig_u_r;
            endcase
          end else begin
            dig_u_nxt_s = dig_u_r;
          end
          if (p_next_s) begin
            case (sel_r)
              SEL_UNITS:    sel_nxt_s = SEL_TENS;
              SEL_TENS:     sel_nxt_s = SEL_HUNDREDS;
              SEL_HUNDREDS: sel_nxt_s = SEL_UNITS;
              default:      sel_nxt_s = SEL_UNITS;
            endcase
          end else begin
            sel_nxt_s = sel_r;
          end
        end
      end
      ST_LOAD: begin
        work_nxt_s = {dig_h_r, dig_t_r, dig_u_r, 9'd0};
        cnt_nxt_s  = 4'd0;
      end
      ST_SHIFT: begin
        work_nxt_s = fixed_s;
        cnt_nxt_s  = cnt_r + 4'd1;
        // Result is registered on the last step so it is present during DONE.
        if (cnt_r == (CONV_STEPS - 4'd1)) begin
          valid_nxt_s = 1'b1;
          if (fixed_s[8]) begin
            value_nxt_s = SAT_VALUE;
            ovf_nxt_s   = 1'b1;
          end else begin
            value_nxt_s = fixed_s[7:0];
            ovf_nxt_s   = 1'b0;
          end
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      ST_DONE: begin
        busy_nxt_s = 1'b0;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      dig_h_r <= 2'd0;
      dig_t_r <= 4'd0;
      dig_u_r <= 4'd0;
      sel_r   <= SEL_UNITS;
      work_r  <= 19'd0;
      cnt_r   <= 4'd0;
      busy_r  <= 1'b0;
      value_r <= 8'd0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      dig_h_r <= dig_h_nxt_s;
      dig_t_r <= dig_t_nxt_s;
      dig_u_r <= dig_u_nxt_s;
      sel_r   <= sel_nxt_s;
      work_r  <= work_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= busy_nxt_s;
      value_r <= value_nxt_s;
      valid_r <= valid_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  assign dig_h = dig_h_r;
  assign dig_t = dig_t_r;
  assign dig_u = dig_u_r;
  assign sel   = sel_r;
  assign busy  = busy_r;
  assign value = value_r;
  assign valid = valid_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_bcd_entry_to_binary.sv
// Scoreboard bench for bcd_entry_to_binary with a short debounce window.
module tb_bcd_entry_to_binary;

  localparam int DEB_CYCLES = 4;
  localparam int DEB_W      = 3;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       btn_inc = 1'b0, btn_next = 1'b0, btn_enter = 1'b0;
  logic [1:0] dig_h, sel;
  logic [3:0] dig_t, dig_u;
  logic       busy, valid, ovf;
  logic [7:0] value;

  bcd_entry_to_binary #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) dut (
    .clk(clk), .clr(clr), .btn_inc(btn_inc), .btn_next(btn_next),
    .btn_enter(btn_enter), .dig_h(dig_h), .dig_t(dig_t), .dig_u(dig_u),
    .sel(sel), .busy(busy), .value(value), .valid(valid), .ovf(ovf));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [8:0] exp_q[$];        // {ovf, value}
  int m_h = 0, m_t = 0, m_u = 0, m_sel = 0;
  int n_valid = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: latency/busy width from the enter pulse, scoreboard pop on valid.
  bit         track = 1'b0, busy_chk = 1'b0;
  int         lat = 0, bcnt = 0;
  logic [8:0] ev;
  always @(negedge clk) begin
    if (!clr) begin
      track = 1'b0;
      busy_chk = 1'b0;
    end else begin
      if (busy_chk) begin
        check_eq("busy_after_done", busy, 0);
        busy_chk = 1'b0;
      end
      if (track) begin
        lat++;
        if (busy) bcnt++;
      end
      if (valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", 1, 0);
        end else begin
          ev = exp_q.pop_front();
          check_eq("value", value, ev[7:0]);
          check_eq("ovf", ovf, ev[8]);
          check_eq("latency", lat, 11);
          check_eq("busy_cycles", bcnt, 11);
          busy_chk = 1'b1;
        end
        track = 1'b0;
      end
      if (dut.p_enter_s && !busy && !track) begin
        track = 1'b1;
        lat = 0;
        bcnt = 0;
      end
    end
  end

  task automatic model_inc();
    case (m_sel)
      0: m_u = (m_u + 1) % 10;
      1: m_t = (m_t + 1) % 10;
      2: m_h = (m_h + 1) % 3;
      default: m_u = m_u;
    endcase
  endtask

  task automatic press(input bit i, input bit n, input bit e);
    @(posedge clk); #1;
    btn_inc = i; btn_next = n; btn_enter = e;
    repeat (8) @(posedge clk);
    #1;
    btn_inc = 1'b0; btn_next = 1'b0; btn_enter = 1'b0;
    repeat (10) @(posedge clk);
    if (i) model_inc();
    if (n) m_sel = (m_sel + 1) % 3;
  endtask

  task automatic check_digits(input string tag);
    @(negedge clk);
    check_eq({tag, ".dig_h"}, dig_h, m_h);
    check_eq({tag, ".dig_t"}, dig_t, m_t);
    check_eq({tag, ".dig_u"}, dig_u, m_u);
    check_eq({tag, ".sel"}, sel, m_sel);
  endtask

  task automatic push_expected();
    int v;
    v = m_h * 100 + m_t * 10 + m_u;
    if (v > 255) exp_q.push_back({1'b1, 8'hFF});
    else         exp_q.push_back({1'b0, v[7:0]});
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    check_eq("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic enter_conv(input string tag);
    push_expected();
    press(1'b0, 1'b0, 1'b1);
    wait_drain();
    check_digits(tag);
  endtask

  task automatic dial(input int h, input int t, input int u);
    while (m_sel != 0) press(1'b0, 1'b1, 1'b0);
    while (m_u != u) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    while (m_t != t) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    while (m_h != h) press(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst.dig_h", dig_h, 0);
    check_eq("rst.dig_t", dig_t, 0);
    check_eq("rst.dig_u", dig_u, 0);
    check_eq("rst.sel", sel, 0);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.value", value, 0);
    check_eq("rst.valid", valid, 0);
    check_eq("rst.ovf", ovf, 0);
    @(posedge clk); #1 clr = 1'b1;
    repeat (3) @(posedge clk);

    // Main conversions and saturation boundaries
    dial(1, 2, 3); check_digits("d123"); enter_conv("c123");
    dial(2, 5, 5); enter_conv("c255");
    dial(2, 5, 6); enter_conv("c256");
    dial(2, 9, 9); enter_conv("c299");
    dial(0, 0, 0); enter_conv("c000");

    // Wrap checks
    while (m_sel != 0) press(1'b0, 1'b1, 1'b0);
    repeat (10) press(1'b1, 1'b0, 1'b0);
    check_digits("wrap_u");
    check_eq("wrap_u.zero", dig_u, 0);
    press(1'b0, 1'b1, 1'b0); press(1'b0, 1'b1, 1'b0);
    repeat (3) press(1'b1, 1'b0, 1'b0);
    check_digits("wrap_h");
    check_eq("wrap_h.zero", dig_h, 0);
    press(1'b0, 1'b1, 1'b0);
    repeat (3) press(1'b0, 1'b1, 1'b0);
    check_eq("wrap_sel", sel, 0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    check_digits("same_cycle");
    check_eq("same_cycle.tens", dig_t, 1);
    check_eq("same_cycle.sel", sel, 2);

    // Bounce: short glitch ignored, bouncy press counts once
    @(posedge clk); #1 btn_inc = 1'b1;
    repeat (3) @(posedge clk);
    #1 btn_inc = 1'b0;
    repeat (10) @(posedge clk);
    check_digits("glitch");
    @(posedge clk); #1 btn_inc = 1'b1;
    repeat (8) @(posedge clk); #1 btn_inc = 1'b0;
    repeat (2) @(posedge clk); #1 btn_inc = 1'b1;
    repeat (2) @(posedge clk); #1 btn_inc = 1'b0;
    repeat (2) @(posedge clk); #1 btn_inc = 1'b1;
    repeat (2) @(posedge clk); #1 btn_inc = 1'b0;
    repeat (12) @(posedge clk);
    model_inc();
    check_digits("bouncy");
    check_eq("bouncy.hund", dig_h, 1);

    // Button activity during a conversion is ignored
    dial(1, 4, 7);
    push_expected();
    @(posedge clk); #1 btn_enter = 1'b1;
    for (int k = 0; k < 30 && !busy; k++) @(negedge clk);
    check_eq("busy_seen", busy, 1);
    @(posedge clk); #1;
    btn_enter = 1'b0; btn_inc = 1'b1; btn_next = 1'b1;
    repeat (8) @(posedge clk); #1;
    btn_inc = 1'b0; btn_next = 1'b0;
    repeat (10) @(posedge clk);
    wait_drain();
    check_digits("busy_press");
    check_eq("busy_press.value", value, 147);

    // Reset mid-conversion aborts without a valid
    nv = n_valid;
    @(posedge clk); #1 btn_enter = 1'b1;
    for (int k = 0; k < 30 && !busy; k++) @(negedge clk);
    check_eq("abort.busy_seen", busy, 1);
    repeat (3) @(posedge clk);
    #2 clr = 1'b0;
    #1;
    check_eq("abort.busy", busy, 0);
    check_eq("abort.valid", valid, 0);
    check_eq("abort.value", value, 0);
    btn_enter = 1'b0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    repeat (25) @(posedge clk);
    @(negedge clk);
    check_eq("abort.no_valid", n_valid, nv);
    m_h = 0; m_t = 0; m_u = 0; m_sel = 0;
    check_digits("abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
